// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed 4-digit seven-segment driver for the century-clock year
//   display (common-anode, active-low anodes and segments). The BCD digits are
//   captured into a shadow register on load and promoted to the active
//   register only at the frame boundary, so one frame never mixes old and new
//   digits. Each digit slot starts with a short all-off gap to avoid ghosting.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   digit3..0   thousands, hundreds, tens, units (BCD)
//   load        one-cycle strobe, captures digit3..0 into the shadow register
//   lz_blank    leading-zero blanking enable, latched at the frame boundary
//   an[3:0]     anode enables, active-low; an[k] selects digit k
//   seg[6:0]    segments {g,f,e,d,c,b,a}, active-low
//   frame_sync  one-cycle pulse after the scan wraps from slot 3 to slot 0
//
// Slot index state machine
//   state | meaning
//   SLOT0 | scanning digit0 (units), an[0] driven
//   SLOT1 | scanning digit1 (tens), an[1] driven
//   SLOT2 | scanning digit2 (hundreds), an[2] driven
//   SLOT3 | scanning digit3 (thousands), an[3] driven

module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GHOST_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic       load,
    input  logic       lz_blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_sync
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GHOST_END  = PW'(GHOST_CYCLES);
    localparam bit            HAS_GHOST  = (GHOST_CYCLES > 0);

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [PW-1:0] prescaler;
    logic [1:0]    slot;
    logic [1:0]    slot_next;
    logic [15:0]   shadow;
    logic [15:0]   active;
    logic [15:0]   load_word;
    logic          lz_active;
    logic          slot_wrap;
    logic          frame_wrap;
    logic          ghost;
    logic          blank3;
    logic          blank2;
    logic          blank1;
    logic [3:0]    cur_code;
    logic          cur_blank;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd15:   s = 7'b0111111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign load_word  = {digit3, digit2, digit1, digit0};
    assign slot_wrap  = (prescaler == PRESC_LAST);
    assign frame_wrap = slot_wrap && (slot == SLOT3);
    assign ghost      = HAS_GHOST && (prescaler < GHOST_END);

    // Blanking cascades downward from the thousands digit; units always shows.
    assign blank3 = lz_active && (active[15:12] == 4'd0);
    assign blank2 = blank3 && (active[11:8] == 4'd0);
    assign blank1 = blank2 && (active[7:4] == 4'd0);

    always_comb begin
        slot_next = SLOT0;
        case (slot)
            SLOT0:   slot_next = SLOT1;
            SLOT1:   slot_next = SLOT2;
            SLOT2:   slot_next = SLOT3;
            default: slot_next = SLOT0;
        endcase
    end

    always_comb begin
        cur_code  = active[3:0];
        cur_blank = 1'b0;
        an_next   = 4'b1110;
        case (slot)
            SLOT0: begin
                cur_code  = active[3:0];
                cur_blank = 1'b0;
                an_next   = 4'b1110;
            end
            SLOT1: begin
                cur_code  = active[7:4];
                cur_blank = blank1;
                an_next   = 4'b1101;
            end
            SLOT2: begin
                cur_code  = active[11:8];
                cur_blank = blank2;
                an_next   = 4'b1011;
            end
            default: begin
                cur_code  = active[15:12];
                cur_blank = blank3;
                an_next   = 4'b0111;
            end
        endcase
        seg_next = seg_encode(cur_code);
        if (cur_blank) begin
            seg_next = SEG_BLANK;
        end
        if (ghost) begin
            an_next  = 4'b1111;
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            slot       <= SLOT0;
            shadow     <= '0;
            active     <= '0;
            lz_active  <= 1'b0;
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            frame_sync <= 1'b0;
        end else begin
            prescaler <= slot_wrap ? '0 : prescaler + 1'b1;
            if (slot_wrap) begin
                slot <= slot_next;
            end
            if (load) begin
                shadow <= load_word;
            end
            // A load coinciding with the frame wrap bypasses the shadow so the
            // new digits appear from slot 0 of the frame that starts now.
            if (frame_wrap) begin
                active    <= load ? load_word : shadow;
                lz_active <= lz_blank;
            end
            an         <= an_next;
            seg        <= seg_next;
            frame_sync <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int REFRESH_DIV  = 8;
    localparam int GHOST_CYCLES = 2;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] SBLK  = 7'b1111111;
    localparam logic [6:0] SDASH = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit3 = 4'd0;
    logic [3:0] digit2 = 4'd0;
    logic [3:0] digit1 = 4'd0;
    logic [3:0] digit0 = 4'd0;
    logic       load = 1'b0;
    logic       lz_blank = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_sync;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int         frame_no;
        logic [6:0] s3;
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
    } exp_t;

    exp_t sb[$];

    seg7_scan_driver #(
        .REFRESH_DIV (REFRESH_DIV),
        .GHOST_CYCLES(GHOST_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digit3    (digit3),
        .digit2    (digit2),
        .digit1    (digit1),
        .digit0    (digit0),
        .load      (load),
        .lz_blank  (lz_blank),
        .an        (an),
        .seg       (seg),
        .frame_sync(frame_sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts frames since reset and, whenever a frame begins whose
    // number matches the head of the scoreboard, checks every slot of it.
    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= rst;

    int   frame_cnt = 0;
    int   cyc = 0;
    int   last_fs = -1;
    int   off = 0;
    bit   chk_on = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        cyc++;
        if (rst_q) begin
            frame_cnt = 0;
            last_fs   = -1;
            chk_on    = 1'b0;
            off       = 0;
        end else begin
            off++;
            if (frame_sync) begin
                frame_cnt++;
                off    = 0;
                chk_on = 1'b0;
                if (last_fs >= 0) chk("fs_period", cyc - last_fs, 4 * REFRESH_DIV);
                last_fs = cyc;
                if (sb.size() > 0 && sb[0].frame_no == frame_cnt) begin
                    cur    = sb.pop_front();
                    chk_on = 1'b1;
                end
            end
            if (chk_on) begin
                for (int s = 0; s < 4; s++) begin
                    logic [3:0] an_exp;
                    logic [6:0] seg_exp;
                    case (s)
                        0:       begin an_exp = 4'b1110; seg_exp = cur.s0; end
                        1:       begin an_exp = 4'b1101; seg_exp = cur.s1; end
                        2:       begin an_exp = 4'b1011; seg_exp = cur.s2; end
                        default: begin an_exp = 4'b0111; seg_exp = cur.s3; end
                    endcase
                    if (off == REFRESH_DIV * s + 1) begin
                        chk($sformatf("f%0d_s%0d_ghost_an", cur.frame_no, s), an, 4'b1111);
                        chk($sformatf("f%0d_s%0d_ghost_seg", cur.frame_no, s), seg, SBLK);
                    end
                    if (off == REFRESH_DIV * s + 6) begin
                        chk($sformatf("f%0d_s%0d_an", cur.frame_no, s), an, an_exp);
                        chk($sformatf("f%0d_s%0d_seg", cur.frame_no, s), seg, seg_exp);
                    end
                end
            end
        end
    end

    task automatic push_frame(input int fn, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        exp_t e;
        e.frame_no = fn;
        e.s3 = s3;
        e.s2 = s2;
        e.s1 = s1;
        e.s0 = s0;
        sb.push_back(e);
    endtask

    // Called at a negedge; load is seen by the following posedge.
    task automatic do_load(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        digit3 = d3;
        digit2 = d2;
        digit1 = d1;
        digit0 = d0;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    // Returns at the negedge where frame_sync is high.
    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_sync && n < 100);
        if (!frame_sync) begin
            errors++;
            $display("FAIL wait_fs: frame_sync not seen within 100 cycles");
        end
    endtask

    // Called at a negedge with reset already sampled; releases it and checks
    // the first slot of the restarted scan.
    task automatic release_checks(input string tag);
        chk({tag, "_rst_an"}, an, 4'b1111);
        chk({tag, "_rst_seg"}, seg, SBLK);
        chk({tag, "_rst_fs"}, frame_sync, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i >= 3 && i <= 8) begin
                chk($sformatf("%s_rel%0d_an", tag, i), an, 4'b1110);
                chk($sformatf("%s_rel%0d_seg", tag, i), seg, S0);
            end else begin
                chk($sformatf("%s_rel%0d_an", tag, i), an, 4'b1111);
                chk($sformatf("%s_rel%0d_seg", tag, i), seg, SBLK);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        release_checks("init");

        // 2024 shown in frame 1
        do_load(4'd2, 4'd0, 4'd2, 4'd4);
        push_frame(1, S2, S0, S2, S4);

        // Loads during frame 1 must not disturb it; frame 2 shows only 2000
        wait_fs();
        repeat (10) @(negedge clk);
        do_load(4'd1, 4'd9, 4'd9, 4'd9);
        repeat (7) @(negedge clk);
        do_load(4'd2, 4'd0, 4'd0, 4'd0);
        push_frame(2, S2, S0, S0, S0);

        // Load exactly in the wrap cycle at the end of frame 2
        wait_fs();
        repeat (31) @(negedge clk);
        push_frame(3, S0, S0, S5, S7);
        do_load(4'd0, 4'd0, 4'd5, 4'd7);

        // Leading-zero blanking, all zeros
        @(negedge clk);
        lz_blank = 1'b1;
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        push_frame(4, SBLK, SBLK, SBLK, S0);

        // Leading-zero blanking, 0105
        wait_fs();
        @(negedge clk);
        do_load(4'd0, 4'd1, 4'd0, 4'd5);
        push_frame(5, SBLK, S1, S0, S5);

        // Invalid codes: 15 dash, 10 blank
        wait_fs();
        @(negedge clk);
        lz_blank = 1'b0;
        do_load(4'd15, 4'd10, 4'd3, 4'd3);
        push_frame(6, SDASH, SBLK, S3, S3);

        // Reset during slot 2 of frame 7
        wait_fs();
        wait_fs();
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        release_checks("mid");
        push_frame(1, S0, S0, S0, S0);

        wait_fs();
        wait_fs();
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed 4-digit seven-segment driver for the century-clock year display. It consumes the BCD digits produced by the divide/modulo stages: thousands, hundreds (the quotient of the divide-by-100 stage), tens and units. It scans them onto a common-anode display with tear-free frame updates, leading-zero blanking and anti-ghosting blank gaps. It sits directly downstream of the digit-extraction logic and drives the board pins.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot. Must be >= GHOST_CYCLES+2.
- GHOST_CYCLES, 500: cycles at the start of each slot with all anodes off. May be 0.
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- digit3  in  4  thousands digit (BCD).
- digit2  in  4  hundreds digit (BCD; quotient of the divide-by-100 stage).
- digit1  in  4  tens digit (BCD).
- digit0  in  4  units digit (BCD).
- load  in  1  one-cycle strobe; capture digit3..0 into the shadow register.
- lz_blank  in  1  enable leading-zero blanking. Sampled at frame boundary, like the digits.
- an  out  4  anode enables, active-low. an[k] selects digitk.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_sync  out  1  one-cycle pulse when the scan wraps from slot 3 to slot 0.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On wrap, the slot index advances 0→1→2→3→0.
- Slot index k drives digit k.
- Shadow register
  - Captured on load.
  - Copied to the active register only at frame wrap: the cycle where the prescaler wraps and the index is 3.
  - A display frame therefore never mixes old and new digits.
- Load in the same cycle as frame wrap: the new inputs go straight into both the shadow and active registers. They are displayed from slot 0 of the new frame.
- Load during reset is ignored.
- Within a slot:
  - Prescaler < GHOST_CYCLES: an=4'b1111 and seg=7'b1111111.
  - Otherwise: an has only bit k low, and seg carries the encoding of active digit k.
- Encoding
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001.
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - Codes 10..14: blank (1111111). Code 15: dash (0111111).
- Leading-zero blanking (active when the latched lz_blank=1):
  - digit3 is blanked if it is 0.
  - digit2 is blanked if it is 0 and digit3 is blanked.
  - digit1 is blanked if it is 0 and digit2 is blanked.
  - digit0 is never blanked.
  - A blanked digit keeps its anode asserted and outputs seg=1111111.
- Slot index state machine: SLOT0..SLOT3, 2-bit. No other states, no illegal states.

## Timing
- Reset values (cycle after rst sampled high):
  - prescaler=0, index=0.
  - shadow and active digits = 0; latched lz_blank = 0.
  - an=4'b1111, seg=7'b1111111, frame_sync=0.
- an, seg and frame_sync are registers. They reflect the (index, prescaler, active) state of the previous cycle, i.e. one-cycle output latency.
- First cycle after reset release has prescaler=0.
  - an first goes low (an=1110) GHOST_CYCLES+1 cycles after reset deasserts.
  - With GHOST_CYCLES=0 this is after 1 cycle.
- Frame period is 4·REFRESH_DIV cycles.
- frame_sync goes high one cycle after the wrap cycle (registered), for exactly one cycle.
- Load-to-display latency
  - Earliest: the next frame wrap plus one cycle.
  - Worst case: 4·REFRESH_DIV+1 cycles.
- Reset mid-slot aborts the scan immediately: outputs are blank on the next cycle, and no partial frame completes.
- Multiple loads within one frame: the last one wins.

## Test plan
- Bench parameters: REFRESH_DIV=8, GHOST_CYCLES=2.
- Reset/first slot
  - Stimulus: assert rst 3 cycles, then release.
  - Required: an=1111 and seg=1111111 for 2 cycles, then an=1110 with seg=1000000 for 6 cycles, then an=1111 again.
- Full scan
  - Stimulus: load 2,0,2,4.
  - Required: after the next frame_sync, slots show an=1110/seg=0011001 (4), 1101/0100100 (2), 1011/1000000 (0), 0111/0100100 (2); frame_sync period is 32 cycles.
- Tear-free update
  - Stimulus: load 1,9,9,9 during slot 1, then 2,0,0,0 during slot 2 of the same frame.
  - Required: the current frame still shows the old digits; the next frame shows 2000 only; 1999 never appears.
- Simultaneous load and wrap
  - Stimulus: load 0,0,5,7 in the wrap cycle.
  - Required: slot 0 of the following frame shows 7 (1111000).
- Leading-zero blanking
  - Stimulus: lz_blank=1, load 0,0,0,0.
  - Required: slots 3..1 show seg=1111111 with their anodes low; slot 0 shows 1000000.
  - Stimulus: load 0,1,0,5.
  - Required: only slot 3 is blank; slot 1 shows 0.
- Reset mid-frame and invalid codes
  - Stimulus: load 15,10,3,3; during slot 2 assert rst for 1 cycle.
  - Required before reset: slot 3 shows dash and slot 2 is blank.
  - Required after reset: outputs blank, active digits = 0, scan restarts at slot 0 showing 0.
